// File: rtl/exec_pkg.sv
// Shared types and constants for the execution unit and its multiplier.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int A0_IDX_DEFAULT = 10;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, low half of the product.
// product is combinational and already includes the bit consumed by the current step.
module iter_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign product  = r_acc + w_addend;
  assign done     = (r_cnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_cnt    <= CW'(DATA_WIDTH - 1);
    end else if (step && !done) begin
      r_acc    <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Handshaked execution datapath: register file, operand mux, 8-op ALU with an
// iterative MUL, registered result with a one-cycle valid pulse and writeback to rd.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_IDX     = A0_IDX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_op_e               alu_op,
  input  logic                  alu_src,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_waddr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_regs [NREG];
  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_eq;
  logic [ADDR_WIDTH-1:0] r_mul_rd;
  logic                  r_mul_eq;

  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_eq;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_mul_start;
  logic                  w_mul_step;
  logic                  w_mul_done;
  logic                  w_mul_finish;
  logic [DATA_WIDTH-1:0] w_mul_product;
  logic                  w_wb_en;
  logic [ADDR_WIDTH-1:0] w_wb_addr;
  logic [DATA_WIDTH-1:0] w_wb_data;

  assign w_op1    = r_regs[rs1];
  assign w_op2    = alu_src ? imm : r_regs[rs2];
  assign w_eq     = (w_op1 == w_op2);
  assign w_accept = in_valid && r_in_ready;
  assign w_is_mul = (alu_op == ALU_MUL);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_alu_result = '0;
    case (alu_op)
      ALU_ADD: w_alu_result = w_op1 + w_op2;
      ALU_SUB: w_alu_result = w_op1 - w_op2;
      ALU_AND: w_alu_result = w_op1 & w_op2;
      ALU_OR:  w_alu_result = w_op1 | w_op2;
      ALU_XOR: w_alu_result = w_op1 ^ w_op2;
      ALU_SLT: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      ALU_SLL: w_alu_result = w_op1 << w_op2[SHW-1:0];
      default: w_alu_result = '0;
    endcase
  end

  assign w_mul_start  = w_accept && w_is_mul;
  assign w_mul_step   = (r_state == ST_MUL);
  assign w_mul_finish = (r_state == ST_MUL) && w_mul_done;

  iter_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .step    (w_mul_step),
    .a       (w_op1),
    .b       (w_op2),
    .product (w_mul_product),
    .done    (w_mul_done)
  );

  // A finishing MUL and a new acceptance never coincide: in_ready is low in ST_MUL.
  assign w_wb_en   = (w_accept && !w_is_mul) || w_mul_finish;
  assign w_wb_addr = w_mul_finish ? r_mul_rd : rd;
  assign w_wb_data = w_mul_finish ? w_mul_product : w_alu_result;

  // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_wb_en && (w_wb_addr == ADDR_WIDTH'(i)))
          r_regs[i] <= w_wb_data;
        else if (ext_we && (ext_waddr == ADDR_WIDTH'(i)))
          r_regs[i] <= ext_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_eq        <= 1'b0;
      r_mul_rd    <= '0;
      r_mul_eq    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_mul) begin
              r_mul_rd   <= rd;
              r_mul_eq   <= w_eq;
              r_in_ready <= 1'b0;
              r_state    <= ST_MUL;
            end else begin
              r_result    <= w_alu_result;
              r_eq        <= w_eq;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_result    <= w_mul_product;
            r_eq        <= r_mul_eq;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign eq        = r_eq;
  assign a0        = r_regs[A0_IDX];

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the register file and operation latencies.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  alu_op_e       alu_op;
  logic          alu_src;
  logic [4:0]    rs1, rs2, rd;
  logic [DW-1:0] imm;
  logic          ext_we;
  logic [4:0]    ext_waddr;
  logic [DW-1:0] ext_wdata;
  logic          out_valid;
  logic [DW-1:0] result;
  logic          eq;
  logic [DW-1:0] a0;

  exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .out_valid(out_valid), .result(result), .eq(eq), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [DW-1:0] mregs [32];
  bit            m_started;
  int            m_rem;
  logic [DW-1:0] m_mul_prod;
  logic [4:0]    m_mul_rd;
  bit            m_mul_eq;
  bit            exp_ov;
  logic [DW-1:0] exp_res;
  bit            exp_eq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 1 : 0;
      6: return a << (b % DW);
      default: begin
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return p[DW-1:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_started = 0;
    m_rem     = 0;
    exp_ov    = 0;
    exp_res   = '0;
    exp_eq    = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, m_started && (m_rem == 0));
    check("result", result, exp_res);
    check("eq", eq, exp_eq);
    check("a0", a0, mregs[10]);
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic step();
    logic [DW-1:0] op1, op2, res, wbd;
    logic [4:0]    wba;
    bit            acc, wb;
    op1 = mregs[rs1];
    op2 = alu_src ? imm : mregs[rs2];
    acc = in_valid && m_started && (m_rem == 0);
    wb  = 0;
    wba = '0;
    wbd = '0;
    exp_ov = 0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        wb = 1; wba = m_mul_rd; wbd = m_mul_prod;
        exp_ov = 1; exp_res = m_mul_prod; exp_eq = m_mul_eq;
      end
    end else if (acc) begin
      if (alu_op == ALU_MUL) begin
        m_rem      = DW;
        m_mul_prod = ref_alu(7, op1, op2);
        m_mul_rd   = rd;
        m_mul_eq   = (op1 == op2);
      end else begin
        res = ref_alu(int'(alu_op), op1, op2);
        exp_ov = 1; exp_res = res; exp_eq = (op1 == op2);
        wb = 1; wba = rd; wbd = res;
      end
    end
    if (ext_we && ext_waddr != 0) mregs[ext_waddr] = ext_wdata;
    if (wb && wba != 0) mregs[wba] = wbd;
    m_started = 1;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cyc(input bit v, input alu_op_e op, input bit src,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
                     input logic [DW-1:0] im, input bit we = 0,
                     input logic [4:0] wa = 0, input logic [DW-1:0] wd = 0);
    in_valid = v; alu_op = op; alu_src = src;
    rs1 = r1; rs2 = r2; rd = rdi; imm = im;
    ext_we = we; ext_waddr = wa; ext_wdata = wd;
    step();
  endtask

  task automatic idle(input bit we = 0, input logic [4:0] wa = 0, input logic [DW-1:0] wd = 0);
    cyc(0, ALU_ADD, 0, 0, 0, 0, '0, we, wa, wd);
  endtask

  // Entered at a falling edge; asserts reset asynchronously between edges.
  task automatic do_reset();
    in_valid = 0; ext_we = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_result", result, '0);
    check("rst_eq", eq, 1'b0);
    check("rst_a0", a0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic zero_sweep();
    for (int i = 0; i < 32; i++) cyc(1, ALU_ADD, 1, 5'(i), 0, 0, '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; alu_op = ALU_ADD; alu_src = 0;
    rs1 = 0; rs2 = 0; rd = 0; imm = '0; ext_we = 0; ext_waddr = 0; ext_wdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic ADD with immediate.
    idle(1, 5, 32'd7);
    cyc(1, ALU_ADD, 1, 5, 0, 10, 32'd3);
    check("add_res", result, 32'd10);
    check("add_a0", a0, 32'd10);
    check("add_eq", eq, 1'b0);

    // Back-to-back: SUB then dependent ADD.
    cyc(1, ALU_SUB, 0, 5, 5, 1, '0);
    check("sub_eq", eq, 1'b1);
    check("sub_ov", out_valid, 1'b1);
    cyc(1, ALU_ADD, 1, 1, 0, 2, 32'd4);
    check("b2b_res", result, 32'd4);
    check("b2b_ov", out_valid, 1'b1);

    // MUL with in_valid held high; ext write to its rs1 mid-operation.
    idle(1, 3, 32'hFFFF_FFFF);
    cyc(1, ALU_MUL, 1, 3, 0, 10, 32'd2);
    check("mul_busy", in_ready, 1'b0);
    for (int i = 0; i < DW; i++)
      cyc(1, ALU_ADD, 1, 0, 0, 7, 32'd5, (i == 4), 3, 32'd0);
    check("mul_res", result, 32'hFFFF_FFFE);
    check("mul_a0", a0, 32'hFFFF_FFFE);
    check("mul_ov", out_valid, 1'b1);
    idle();

    // SLT signed, SLL masked shift, writes to x0.
    idle(1, 4, 32'h8000_0000);
    cyc(1, ALU_SLT, 1, 4, 0, 6, 32'd1, 1, 8, 32'd1);
    check("slt_res", result, 32'd1);
    cyc(1, ALU_SLL, 1, 8, 0, 9, 32'd33);
    check("sll_res", result, 32'd2);
    cyc(1, ALU_ADD, 1, 5, 0, 0, 32'd3);
    cyc(1, ALU_ADD, 1, 0, 0, 0, '0);
    check("x0_zero", result, '0);

    // Same-edge ext write and writeback to x10: writeback wins.
    cyc(1, ALU_ADD, 1, 5, 0, 10, 32'd1, 1, 10, 32'hDEAD);
    idle();
    check("wb_wins", a0, 32'd8);
    cyc(1, ALU_ADD, 1, 10, 0, 11, '0, 1, 12, 32'h55);
    cyc(1, ALU_OR, 0, 11, 12, 13, '0);
    check("both_written", result, 32'h5D);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      alu_op_e op;
      op = alu_op_e'($urandom_range(0, 7));
      if (op == ALU_MUL && $urandom_range(0, 3) != 0) op = ALU_XOR;
      cyc($urandom_range(0, 3) != 0, op, 1'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
          1'($urandom), 5'($urandom), $urandom);
    end
    for (int i = 0; i < DW + 1; i++) idle();

    // Reset in the middle of a MUL.
    idle(1, 3, 32'd12345);
    cyc(1, ALU_MUL, 0, 3, 3, 10, '0);
    for (int i = 0; i < 9; i++) idle();
    do_reset();
    for (int i = 0; i < DW + 4; i++) idle();
    zero_sweep();
    idle(1, 5, 32'd7);
    cyc(1, ALU_ADD, 1, 5, 0, 10, 32'd3);
    check("post_rst_add", result, 32'd10);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Parametrised, handshaked execution datapath for the single-cycle core.
- Contains a register file (2 read ports, 1 internal writeback port, 1 external write port) and an immediate/register operand mux.
- Contains an 8-op ALU; MUL runs as an iterative multi-cycle operation.
- Registered result with valid pulse and automatic writeback to rd; a0 exported for testbench/display.

Parameters:
- DATA_WIDTH, 32, operand/register width (>=8, power of 2).
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- A0_IDX, 10, register index exported on a0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_op  in  3  operation select (exec_pkg::alu_op_e).
- alu_src  in  1  0: op2 = RD2; 1: op2 = imm.
- rs1  in  ADDR_WIDTH  source 1 index.
- rs2  in  ADDR_WIDTH  source 2 index.
- rd  in  ADDR_WIDTH  destination index.
- imm  in  DATA_WIDTH  immediate operand.
- ext_we  in  1  external write enable (load writeback).
- ext_waddr  in  ADDR_WIDTH  external write index.
- ext_wdata  in  DATA_WIDTH  external write data.
- out_valid  out  1  one-cycle pulse: result/eq valid, rd written.
- result  out  DATA_WIDTH  registered result.
- eq  out  1  registered (op1 == op2) of the completed operation.
- a0  out  DATA_WIDTH  current content of register A0_IDX.

Behaviour:
- Reset (rst low, async):
  - all registers, result and counter = 0; eq = 0, out_valid = 0; state = IDLE.
  - in_ready = 1 from the first edge after release.
  - Reset during MUL aborts it; no writeback occurs.
- Register file:
  - Combinational reads.
  - Index 0 reads 0; writes to index 0 are discarded.
  - Writes occur at the rising edge.
  - Same-edge internal writeback and ext write to the same nonzero index: internal writeback wins. Different indices: both written.
- Acceptance: in_valid && in_ready at an edge.
  - Operands are sampled from the combinational reads in that cycle.
  - No bypass is needed, because a write landing at edge E is visible to an acceptance at edge E+1.
- FSM states: IDLE, MUL.
  - IDLE: in_ready = 1.
    - Accept non-MUL: compute, register result/eq, write rd, out_valid = 1 next cycle; stay IDLE.
    - Accept MUL: latch op1, op2, rd, eq; counter = DATA_WIDTH-1; go to MUL.
  - MUL: in_ready = 0; one shift-add step per cycle.
    - When counter == 0 at an edge: register the product, write rd, pulse out_valid, return to IDLE.
  - Total MUL latency: DATA_WIDTH edges from acceptance to writeback edge. Non-MUL latency: 1.
- Back-to-back non-MUL operations sustain one per cycle.
- out_valid has no backpressure; it is high exactly one cycle per completed operation. result and eq hold until the next completion.
- Ops (op1 = RD1, op2 = mux output), all results mod 2**DATA_WIDTH:
  - ADD = 0: op1 + op2.
  - SUB = 1: op1 - op2.
  - AND = 2: op1 & op2.
  - OR = 3: op1 | op2.
  - XOR = 4: op1 ^ op2.
  - SLT = 5: signed op1 < op2 gives 1, else 0.
  - SLL = 6: op1 << op2[$clog2(DATA_WIDTH)-1:0].
  - MUL = 7: low DATA_WIDTH bits of the unsigned product (equal to the signed low half).
- eq is computed on op1/op2 at acceptance, for every op.
- ext writes are honoured in every state, including during MUL.
  - A MUL's operands are latched at acceptance, so later ext writes to rs1/rs2 do not affect it.

Decomposition:
- exec_pkg holds:
  - alu_op_e (3-bit enum: ADD, SUB, AND, OR, XOR, SLT, SLL, MUL)
  - state_e (IDLE, MUL)
  - default A0_IDX constant
- Sub-module iter_mul: holds the shift-add multiplier (start, step, a, b, product, done), parametrised on DATA_WIDTH.
- Register file and ALU remain inside exec_unit.

Test Plan:
- Reset, then ext write x5=7, then ADD rs1=5, imm=3, alu_src=1, rd=10 -> out_valid one cycle after accept; result=10, a0=10, eq=0.
- Back-to-back, no gaps: SUB x1=x5-x5 (rd=1), then ADD x2=x1+imm 4 -> eq=1 on the first; second result=4 (x1=0 seen); out_valid high two consecutive cycles.
- MUL x3=0xFFFF_FFFF × imm 2, rd=10 -> in_ready=0 for 32 cycles; in_valid is held high during that time and nothing is accepted; result=0xFFFF_FFFE, a0 updates on the writeback edge.
- SLT with op1=0x8000_0000, op2=1 -> 1. SLL with op1=1, op2=33 -> 2 (shift amount masked). Writes with rd=0 -> x0 stays 0.
- Ext write and ADD writeback both to x10 on the same edge -> ADD result stored. During MUL, ext write to its rs1 -> product unaffected.
- Assert rst mid-MUL (cycle 10) -> out_valid never pulses; all registers 0; in_ready=1 after release; a fresh ADD then completes normally.
